reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station_pkg.sv | 33 +++
 rtl/reservation_station_select.sv | 23 ++
 rtl/reservation_station.sv | 169 ++++++++++++++++
 tb/tb_reservation_station.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared widths, opcode encodings and the entry record used by the reservation station.
package reservation_station_pkg;

    localparam int INSIDE_OPCODE_WIDTH = 6;
    localparam int DATA_WIDTH          = 32;
    localparam int ROB_TAG_WIDTH       = 4;

    typedef enum logic [INSIDE_OPCODE_WIDTH-1:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd2,
        OP_ADDI = 6'd3,
        OP_AND  = 6'd4,
        OP_OR   = 6'd5,
        OP_XOR  = 6'd6,
        OP_SLL  = 6'd7
    } opcode_e;

    typedef struct packed {
        logic                           busy;
        logic [INSIDE_OPCODE_WIDTH-1:0] op;
        logic [DATA_WIDTH-1:0]          vj;
        logic [DATA_WIDTH-1:0]          vk;
        logic                           qj_valid;
        logic [ROB_TAG_WIDTH-1:0]       qj;
        logic                           qk_valid;
        logic [ROB_TAG_WIDTH-1:0]       qk;
        logic [DATA_WIDTH-1:0]          imm;
        logic [DATA_WIDTH-1:0]          pc;
        logic [ROB_TAG_WIDTH-1:0]       rob;
    } rs_entry_t;

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder shared by free-slot and ready-entry selection.
module rs_select #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest requesting index is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = i[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: dispatch into free slots, CDB wakeup, in-order-by-index issue to the ALU.
// Define RS_CDB_BYPASS_EN to capture same-cycle CDB results on dispatch.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           in_flush,
    input  logic                           in_disp_valid,
    input  logic [INSIDE_OPCODE_WIDTH-1:0] in_disp_op,
    input  logic [DATA_WIDTH-1:0]          in_disp_vj,
    input  logic [DATA_WIDTH-1:0]          in_disp_vk,
    input  logic                           in_disp_qj_valid,
    input  logic                           in_disp_qk_valid,
    input  logic [ROB_TAG_WIDTH-1:0]       in_disp_qj,
    input  logic [ROB_TAG_WIDTH-1:0]       in_disp_qk,
    input  logic [DATA_WIDTH-1:0]          in_disp_imm,
    input  logic [DATA_WIDTH-1:0]          in_disp_pc,
    input  logic [ROB_TAG_WIDTH-1:0]       in_disp_rob,
    input  logic                           in_cdb_alu_valid,
    input  logic [ROB_TAG_WIDTH-1:0]       in_cdb_alu_tag,
    input  logic [DATA_WIDTH-1:0]          in_cdb_alu_value,
    input  logic                           in_cdb_lsb_valid,
    input  logic [ROB_TAG_WIDTH-1:0]       in_cdb_lsb_tag,
    input  logic [DATA_WIDTH-1:0]          in_cdb_lsb_value,
    output logic                           out_full,
    output logic                           out_alu_valid,
    output logic [INSIDE_OPCODE_WIDTH-1:0] out_alu_op,
    output logic [DATA_WIDTH-1:0]          out_alu_rs1,
    output logic [DATA_WIDTH-1:0]          out_alu_rs2,
    output logic [DATA_WIDTH-1:0]          out_alu_imm,
    output logic [DATA_WIDTH-1:0]          out_alu_pc,
    output logic [ROB_TAG_WIDTH-1:0]       out_alu_rob
);

    localparam int IDX_W = $clog2(DEPTH);

    rs_entry_t        entries [DEPTH];
    rs_entry_t        disp_entry;
    logic [DEPTH-1:0] busy_vec;
    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] ready_vec;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] ready_idx;
    logic             free_found;
    logic             ready_found;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_vec[i]  = entries[i].busy;
            ready_vec[i] = entries[i].busy & ~entries[i].qj_valid & ~entries[i].qk_valid;
        end
    end

    assign free_vec = ~busy_vec;
    assign out_full = &busy_vec;

    rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_free_sel (
        .req   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ready_sel (
        .req   (ready_vec),
        .idx   (ready_idx),
        .found (ready_found)
    );

    always_comb begin
        disp_entry.busy     = 1'b1;
        disp_entry.op       = in_disp_op;
        disp_entry.vj       = in_disp_vj;
        disp_entry.vk       = in_disp_vk;
        disp_entry.qj_valid = in_disp_qj_valid;
        disp_entry.qj       = in_disp_qj;
        disp_entry.qk_valid = in_disp_qk_valid;
        disp_entry.qk       = in_disp_qk;
        disp_entry.imm      = in_disp_imm;
        disp_entry.pc       = in_disp_pc;
        disp_entry.rob      = in_disp_rob;
`ifdef RS_CDB_BYPASS_EN
        // A result broadcast in the same cycle as dispatch would otherwise be missed forever.
        if (in_disp_qj_valid) begin
            if (in_cdb_alu_valid && in_cdb_alu_tag == in_disp_qj) begin
                disp_entry.vj       = in_cdb_alu_value;
                disp_entry.qj_valid = 1'b0;
            end else if (in_cdb_lsb_valid && in_cdb_lsb_tag == in_disp_qj) begin
                disp_entry.vj       = in_cdb_lsb_value;
                disp_entry.qj_valid = 1'b0;
            end
        end
        if (in_disp_qk_valid) begin
            if (in_cdb_alu_valid && in_cdb_alu_tag == in_disp_qk) begin
                disp_entry.vk       = in_cdb_alu_value;
                disp_entry.qk_valid = 1'b0;
            end else if (in_cdb_lsb_valid && in_cdb_lsb_tag == in_disp_qk) begin
                disp_entry.vk       = in_cdb_lsb_value;
                disp_entry.qk_valid = 1'b0;
            end
        end
`endif
    end

    // Wakeup, issue and dispatch all act on pre-edge state; the dispatch slot is never busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            out_alu_valid <= 1'b0;
            out_alu_op    <= '0;
            out_alu_rs1   <= '0;
            out_alu_rs2   <= '0;
            out_alu_imm   <= '0;
            out_alu_pc    <= '0;
            out_alu_rob   <= '0;
        end else if (rdy) begin
            if (in_flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    entries[i].busy <= 1'b0;
                end
                out_alu_valid <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entries[i].busy && entries[i].qj_valid) begin
                        if (in_cdb_alu_valid && in_cdb_alu_tag == entries[i].qj) begin
                            entries[i].vj       <= in_cdb_alu_value;
                            entries[i].qj_valid <= 1'b0;
                        end else if (in_cdb_lsb_valid && in_cdb_lsb_tag == entries[i].qj) begin
                            entries[i].vj       <= in_cdb_lsb_value;
                            entries[i].qj_valid <= 1'b0;
                        end
                    end
                    if (entries[i].busy && entries[i].qk_valid) begin
                        if (in_cdb_alu_valid && in_cdb_alu_tag == entries[i].qk) begin
                            entries[i].vk       <= in_cdb_alu_value;
                            entries[i].qk_valid <= 1'b0;
                        end else if (in_cdb_lsb_valid && in_cdb_lsb_tag == entries[i].qk) begin
                            entries[i].vk       <= in_cdb_lsb_value;
                            entries[i].qk_valid <= 1'b0;
                        end
                    end
                end

                out_alu_valid <= ready_found;
                if (ready_found) begin
                    out_alu_op                <= entries[ready_idx].op;
                    out_alu_rs1               <= entries[ready_idx].vj;
                    out_alu_rs2               <= entries[ready_idx].vk;
                    out_alu_imm               <= entries[ready_idx].imm;
                    out_alu_pc                <= entries[ready_idx].pc;
                    out_alu_rob               <= entries[ready_idx].rob;
                    entries[ready_idx].busy   <= 1'b0;
                end

                if (in_disp_valid && free_found) begin
                    entries[free_idx] <= disp_entry;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard-driven bench for reservation_station (default DEPTH=8); honours RS_CDB_BYPASS_EN.
module tb_reservation_station;
    import reservation_station_pkg::*;

    typedef struct packed {
        logic [INSIDE_OPCODE_WIDTH-1:0] op;
        logic [DATA_WIDTH-1:0]          rs1;
        logic [DATA_WIDTH-1:0]          rs2;
        logic [DATA_WIDTH-1:0]          imm;
        logic [DATA_WIDTH-1:0]          pc;
        logic [ROB_TAG_WIDTH-1:0]       rob;
    } issue_t;

    logic                           clk = 1'b0;
    logic                           rst, rdy, in_flush, in_disp_valid;
    logic [INSIDE_OPCODE_WIDTH-1:0] in_disp_op;
    logic [DATA_WIDTH-1:0]          in_disp_vj, in_disp_vk, in_disp_imm, in_disp_pc;
    logic                           in_disp_qj_valid, in_disp_qk_valid;
    logic [ROB_TAG_WIDTH-1:0]       in_disp_qj, in_disp_qk, in_disp_rob;
    logic                           in_cdb_alu_valid, in_cdb_lsb_valid;
    logic [ROB_TAG_WIDTH-1:0]       in_cdb_alu_tag, in_cdb_lsb_tag;
    logic [DATA_WIDTH-1:0]          in_cdb_alu_value, in_cdb_lsb_value;
    logic                           out_full, out_alu_valid;
    logic [INSIDE_OPCODE_WIDTH-1:0] out_alu_op;
    logic [DATA_WIDTH-1:0]          out_alu_rs1, out_alu_rs2, out_alu_imm, out_alu_pc;
    logic [ROB_TAG_WIDTH-1:0]       out_alu_rob;

    int     checks = 0;
    int     errors = 0;
    issue_t exp_q[$];
    issue_t exp;

    reservation_station #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_flush(in_flush),
        .in_disp_valid(in_disp_valid), .in_disp_op(in_disp_op),
        .in_disp_vj(in_disp_vj), .in_disp_vk(in_disp_vk),
        .in_disp_qj_valid(in_disp_qj_valid), .in_disp_qk_valid(in_disp_qk_valid),
        .in_disp_qj(in_disp_qj), .in_disp_qk(in_disp_qk),
        .in_disp_imm(in_disp_imm), .in_disp_pc(in_disp_pc), .in_disp_rob(in_disp_rob),
        .in_cdb_alu_valid(in_cdb_alu_valid), .in_cdb_alu_tag(in_cdb_alu_tag),
        .in_cdb_alu_value(in_cdb_alu_value),
        .in_cdb_lsb_valid(in_cdb_lsb_valid), .in_cdb_lsb_tag(in_cdb_lsb_tag),
        .in_cdb_lsb_value(in_cdb_lsb_value),
        .out_full(out_full), .out_alu_valid(out_alu_valid), .out_alu_op(out_alu_op),
        .out_alu_rs1(out_alu_rs1), .out_alu_rs2(out_alu_rs2), .out_alu_imm(out_alu_imm),
        .out_alu_pc(out_alu_pc), .out_alu_rob(out_alu_rob)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic issue_t observed();
        issue_t o;
        o.op  = out_alu_op;
        o.rs1 = out_alu_rs1;
        o.rs2 = out_alu_rs2;
        o.imm = out_alu_imm;
        o.pc  = out_alu_pc;
        o.rob = out_alu_rob;
        return o;
    endfunction

    task automatic clear_inputs();
        in_flush = 0; in_disp_valid = 0; in_disp_op = '0;
        in_disp_vj = '0; in_disp_vk = '0; in_disp_imm = '0; in_disp_pc = '0;
        in_disp_qj_valid = 0; in_disp_qk_valid = 0;
        in_disp_qj = '0; in_disp_qk = '0; in_disp_rob = '0;
        in_cdb_alu_valid = 0; in_cdb_alu_tag = '0; in_cdb_alu_value = '0;
        in_cdb_lsb_valid = 0; in_cdb_lsb_tag = '0; in_cdb_lsb_value = '0;
    endtask

    task automatic drive_disp(input logic [INSIDE_OPCODE_WIDTH-1:0] op,
                              input logic [DATA_WIDTH-1:0] vj, input logic [DATA_WIDTH-1:0] vk,
                              input logic qjv, input logic [ROB_TAG_WIDTH-1:0] qj,
                              input logic qkv, input logic [ROB_TAG_WIDTH-1:0] qk,
                              input logic [DATA_WIDTH-1:0] imm, input logic [DATA_WIDTH-1:0] pc,
                              input logic [ROB_TAG_WIDTH-1:0] rob);
        in_disp_valid = 1; in_disp_op = op; in_disp_vj = vj; in_disp_vk = vk;
        in_disp_qj_valid = qjv; in_disp_qj = qj; in_disp_qk_valid = qkv; in_disp_qk = qk;
        in_disp_imm = imm; in_disp_pc = pc; in_disp_rob = rob;
    endtask

    task automatic test_reset();
        rst = 1; rdy = 1; clear_inputs();
        #12;
        checks++;
        if (out_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b want 0", out_full); end
        checks++;
        if (out_alu_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", out_alu_valid); end
        checks++;
        if (observed() !== issue_t'(0)) begin errors++; $display("[TB] FAIL reset_fields got %h want 0", observed()); end
        @(negedge clk); rst = 0;
        tick();
    endtask

    task automatic test_single_addi();
        drive_disp(OP_ADDI, 32'd5, 32'd0, 0, '0, 0, '0, 32'd7, 32'h100, 4'd3);
        exp_q.push_back('{op: OP_ADDI, rs1: 32'd5, rs2: 32'd0, imm: 32'd7, pc: 32'h100, rob: 4'd3});
        tick();
        clear_inputs();
        checks++;
        if (out_alu_valid !== 1'b0) begin errors++; $display("[TB] FAIL addi_early got %b want 0", out_alu_valid); end
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (out_alu_valid !== 1'b1 || observed() !== exp) begin
            errors++; $display("[TB] FAIL addi_issue got v=%b %h want v=1 %h", out_alu_valid, observed(), exp);
        end
        tick();
        checks++;
        if (out_alu_valid !== 1'b0) begin errors++; $display("[TB] FAIL addi_oneshot got %b want 0", out_alu_valid); end
    endtask

    task automatic test_wakeup();
        drive_disp(OP_ADD, 32'hDEAD, 32'd1, 1, 4'd5, 0, '0, 32'd0, 32'h104, 4'd2);
        exp_q.push_back('{op: OP_ADD, rs1: 32'h10, rs2: 32'd1, imm: 32'd0, pc: 32'h104, rob: 4'd2});
        tick();
        clear_inputs();
        tick();
        in_cdb_alu_valid = 1; in_cdb_alu_tag = 4'd5; in_cdb_alu_value = 32'h10;
        tick();
        clear_inputs();
        checks++;
        if (out_alu_valid !== 1'b0) begin errors++; $display("[TB] FAIL wake_early got %b want 0", out_alu_valid); end
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (out_alu_valid !== 1'b1 || observed() !== exp) begin
            errors++; $display("[TB] FAIL wake_issue got v=%b %h want v=1 %h", out_alu_valid, observed(), exp);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            drive_disp(OP_ADD, 32'd0, 32'(i), 1, 4'(8 + i), 0, '0, 32'd0, 32'(32'h200 + 4 * i), 4'(i));
            tick();
        end
        clear_inputs();
        checks++;
        if (out_full !== 1'b1) begin errors++; $display("[TB] FAIL full_set got %b want 1", out_full); end
        drive_disp(OP_ADDI, 32'd1, 32'd0, 0, '0, 0, '0, 32'd1, 32'h2FC, 4'd15);
        tick();
        clear_inputs();
        in_cdb_lsb_valid = 1; in_cdb_lsb_tag = 4'd8; in_cdb_lsb_value = 32'h55;
        exp_q.push_back('{op: OP_ADD, rs1: 32'h55, rs2: 32'd0, imm: 32'd0, pc: 32'h200, rob: 4'd0});
        tick();
        clear_inputs();
        checks++;
        if (out_alu_valid !== 1'b0 || out_full !== 1'b1) begin
            errors++; $display("[TB] FAIL full_ninth got v=%b full=%b want v=0 full=1", out_alu_valid, out_full);
        end
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (out_alu_valid !== 1'b1 || observed() !== exp) begin
            errors++; $display("[TB] FAIL full_issue got v=%b %h want v=1 %h", out_alu_valid, observed(), exp);
        end
        checks++;
        if (out_full !== 1'b0) begin errors++; $display("[TB] FAIL full_release got %b want 0", out_full); end
        in_flush = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_priority_and_flush();
        int issued;
        for (int i = 0; i < 5; i++) begin
            drive_disp(OP_SUB, 32'd0, 32'(32'h100 + i), 1, 4'(i), 0, '0, 32'd0, 32'(32'h300 + 4 * i), 4'(10 + i));
            tick();
        end
        clear_inputs();
        in_cdb_alu_valid = 1; in_cdb_alu_tag = 4'd1; in_cdb_alu_value = 32'h11;
        in_cdb_lsb_valid = 1; in_cdb_lsb_tag = 4'd4; in_cdb_lsb_value = 32'h44;
        exp_q.push_back('{op: OP_SUB, rs1: 32'h11, rs2: 32'h101, imm: 32'd0, pc: 32'h304, rob: 4'd11});
        exp_q.push_back('{op: OP_SUB, rs1: 32'h44, rs2: 32'h104, imm: 32'd0, pc: 32'h310, rob: 4'd14});
        tick();
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (out_alu_valid !== 1'b1 || observed() !== exp) begin
                errors++; $display("[TB] FAIL prio_issue%0d got v=%b %h want v=1 %h", k, out_alu_valid, observed(), exp);
            end
        end
        drive_disp(OP_SUB, 32'd0, 32'd0, 1, 4'd7, 0, '0, 32'd0, 32'h400, 4'd5);
        tick();
        drive_disp(OP_SUB, 32'd0, 32'd0, 1, 4'd9, 0, '0, 32'd0, 32'h404, 4'd6);
        tick();
        clear_inputs();
        in_cdb_alu_valid = 1; in_cdb_alu_tag = 4'd0; in_cdb_alu_value = 32'h1;
        tick();
        clear_inputs();
        in_flush = 1;
        drive_disp(OP_ADDI, 32'd0, 32'd0, 0, '0, 0, '0, 32'd0, 32'h500, 4'd8);
        tick();
        clear_inputs();
        checks++;
        if (out_alu_valid !== 1'b0 || out_full !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_now got v=%b full=%b want v=0 full=0", out_alu_valid, out_full);
        end
        issued = 0;
        for (int k = 0; k < 6; k++) begin
            in_cdb_lsb_valid = 1;
            in_cdb_lsb_tag = (k == 0) ? 4'd2 : (k == 1) ? 4'd3 : (k == 2) ? 4'd7 : 4'd9;
            tick();
            if (out_alu_valid) issued++;
        end
        clear_inputs();
        checks++;
        if (issued !== 0) begin errors++; $display("[TB] FAIL flush_stale got %0d issues want 0", issued); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                drive_disp(OP_ADDI, 32'(32'h1000 + k), 32'd0, 0, '0, 0, '0, 32'(k), 32'(32'h600 + 4 * k), 4'(k));
                exp_q.push_back('{op: OP_ADDI, rs1: 32'(32'h1000 + k), rs2: 32'd0, imm: 32'(k),
                                  pc: 32'(32'h600 + 4 * k), rob: 4'(k)});
            end else begin
                clear_inputs();
            end
            tick();
            if (k > 0) begin
                exp = exp_q.pop_front();
                checks++;
                if (out_alu_valid !== 1'b1 || observed() !== exp) begin
                    errors++; $display("[TB] FAIL b2b_issue%0d got v=%b %h want v=1 %h", k, out_alu_valid, observed(), exp);
                end
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_rdy_freeze();
        int issued;
        drive_disp(OP_XOR, 32'd3, 32'd4, 0, '0, 0, '0, 32'd0, 32'h700, 4'd7);
        tick();
        clear_inputs();
        tick();
        rdy = 0;
        drive_disp(OP_ADDI, 32'd9, 32'd0, 0, '0, 0, '0, 32'd0, 32'h704, 4'd8);
        tick();
        tick();
        checks++;
        if (out_alu_valid !== 1'b1 || out_alu_rob !== 4'd7) begin
            errors++; $display("[TB] FAIL rdy_hold got v=%b rob=%0d want v=1 rob=7", out_alu_valid, out_alu_rob);
        end
        rdy = 1;
        clear_inputs();
        issued = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (out_alu_valid) issued++;
        end
        checks++;
        if (issued !== 0) begin errors++; $display("[TB] FAIL rdy_ignore got %0d issues want 0", issued); end
    endtask

    task automatic test_reset_mid();
        drive_disp(OP_OR, 32'd1, 32'd2, 0, '0, 0, '0, 32'd0, 32'h800, 4'd9);
        tick();
        clear_inputs();
        rst = 1;
        #2;
        checks++;
        if (out_full !== 1'b0 || out_alu_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_async got v=%b full=%b want 0 0", out_alu_valid, out_full);
        end
        rst = 0;
        tick();
        checks++;
        if (out_alu_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_discard got %b want 0", out_alu_valid); end
    endtask

    task automatic test_bypass();
        int issued;
        drive_disp(OP_ADD, 32'd0, 32'd2, 1, 4'd6, 0, '0, 32'd0, 32'h900, 4'd4);
        in_cdb_lsb_valid = 1; in_cdb_lsb_tag = 4'd6; in_cdb_lsb_value = 32'hAA;
        tick();
        clear_inputs();
`ifdef RS_CDB_BYPASS_EN
        exp_q.push_back('{op: OP_ADD, rs1: 32'hAA, rs2: 32'd2, imm: 32'd0, pc: 32'h900, rob: 4'd4});
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (out_alu_valid !== 1'b1 || observed() !== exp) begin
            errors++; $display("[TB] FAIL bypass_issue got v=%b %h want v=1 %h", out_alu_valid, observed(), exp);
        end
`else
        issued = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (out_alu_valid) issued++;
        end
        checks++;
        if (issued !== 0) begin errors++; $display("[TB] FAIL no_bypass got %0d issues want 0", issued); end
`endif
        issued = 0;
        in_flush = 1;
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_addi();
        test_wakeup();
        test_full();
        test_priority_and_flush();
        test_back_to_back();
        test_rdy_freeze();
        test_reset_mid();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
